// File: rtl/order_generator.sv
// Three-slot customer order generator: staggered refills, LFSR-chosen recipes, patience timers,
// score/miss tracking and sticky game_over. Define ORDER_GEN_NO_REPEAT_EN to keep active recipes distinct.
module order_generator #(
  parameter int unsigned TICK_DIV      = 100_000_000,
  parameter int unsigned ORDER_TIMEOUT = 45,
  parameter int unsigned REFILL_TICKS  = 3,
  parameter int unsigned MAX_MISSES    = 5,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        basys_clk,
  input  logic        reset,
  input  logic [2:0]  orders_done,
  output logic [11:0] order_1,
  output logic [11:0] order_2,
  output logic [11:0] order_3,
  output logic [2:0]  order_valid,
  output logic [2:0]  new_order,
  output logic [5:0]  time_left_1,
  output logic [5:0]  time_left_2,
  output logic [5:0]  time_left_3,
  output logic [7:0]  score,
  output logic [3:0]  missed,
  output logic        game_over
);

  localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {StEmpty, StActive} slot_st_e;

  slot_st_e         state_q  [3];
  logic [3:0]       refill_q [3];
  logic [5:0]       time_q   [3];
  logic [11:0]      order_q  [3];
  logic [2:0]       new_order_q, done_q;
  logic [PresW-1:0] presc_q;
  logic [15:0]      lfsr_q;
  logic [7:0]       score_q;
  logic [3:0]       missed_q;
  logic             game_over_q;

  logic       tick;
  logic [2:0] done_rise, complete, expire, fill;
  logic [2:0] fill_idx [3];
  logic [1:0] n_done, n_miss;
  logic [8:0] score_sum;
  logic [4:0] miss_sum;
  logic [7:0] score_d;
  logic [3:0] missed_d;

  function automatic logic [11:0] recipe_rom(input logic [2:0] idx);
    logic [11:0] w;
    unique case (idx)
      3'd0: w = 12'h002;
      3'd1: w = 12'h010;
      3'd2: w = 12'h0C0;
      3'd3: w = 12'h600;
      3'd4: w = 12'h012;
      3'd5: w = 12'h6C0;
      3'd6: w = 12'h610;
      3'd7: w = 12'h6D2;
    endcase
    return w;
  endfunction

  always_comb begin
    tick      = (presc_q == PresW'(TICK_DIV - 1));
    done_rise = orders_done & ~done_q;
    n_done    = '0;
    n_miss    = '0;
    for (int i = 0; i < 3; i++) begin
      complete[i] = (state_q[i] == StActive) && done_rise[i];
      // Completion beats expiry when both land on the same cycle.
      expire[i]   = (state_q[i] == StActive) && !done_rise[i] && tick && (time_q[i] == 6'd1);
      fill[i]     = (state_q[i] == StEmpty) && tick && (refill_q[i] == 4'd1);
      n_done      = n_done + {1'b0, complete[i]};
      n_miss      = n_miss + {1'b0, expire[i]};
    end
    score_sum = {1'b0, score_q} + {7'd0, n_done};
    score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
    miss_sum  = {1'b0, missed_q} + {3'd0, n_miss};
    missed_d  = (miss_sum >= 5'(MAX_MISSES)) ? 4'(MAX_MISSES) : miss_sum[3:0];
  end

`ifdef ORDER_GEN_NO_REPEAT_EN
  logic [2:0] idx_q [3];
  logic [2:0] cand;
  logic       hit;

  // Earlier slots resolve first so later fills also avoid their fresh picks.
  always_comb begin
    cand = '0;
    hit  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cand = lfsr_q[3*i +: 3];
      for (int k = 0; k < 3; k++) begin
        hit = 1'b0;
        for (int j = 0; j < 3; j++) begin
          if (j != i) begin
            if ((state_q[j] == StActive && idx_q[j] == cand) ||
                (j < i && fill[j] && fill_idx[j] == cand)) begin
              hit = 1'b1;
            end
          end
        end
        if (hit) cand = cand + 3'd1;
      end
      fill_idx[i] = cand;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 3; i++) fill_idx[i] = lfsr_q[3*i +: 3];
  end
`endif

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i]  <= StEmpty;
        refill_q[i] <= 4'(i + 1);
        time_q[i]   <= '0;
        order_q[i]  <= '0;
`ifdef ORDER_GEN_NO_REPEAT_EN
        idx_q[i]    <= '0;
`endif
      end
      new_order_q <= '0;
      done_q      <= '0;
      presc_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      score_q     <= '0;
      missed_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      done_q <= orders_done;
      if (!game_over_q) begin
        presc_q     <= tick ? '0 : presc_q + PresW'(1);
        lfsr_q      <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        score_q     <= score_d;
        missed_q    <= missed_d;
        game_over_q <= (missed_q == 4'(MAX_MISSES));
        new_order_q <= fill;
        for (int i = 0; i < 3; i++) begin
          unique case (state_q[i])
            StEmpty: begin
              if (tick) refill_q[i] <= refill_q[i] - 4'd1;
              if (fill[i]) begin
                state_q[i] <= StActive;
                order_q[i] <= recipe_rom(fill_idx[i]);
                time_q[i]  <= 6'(ORDER_TIMEOUT);
`ifdef ORDER_GEN_NO_REPEAT_EN
                idx_q[i]   <= fill_idx[i];
`endif
              end
            end
            StActive: begin
              if (complete[i] || expire[i]) begin
                state_q[i]  <= StEmpty;
                order_q[i]  <= '0;
                time_q[i]   <= '0;
                refill_q[i] <= 4'(REFILL_TICKS);
              end else if (tick) begin
                time_q[i] <= time_q[i] - 6'd1;
              end
            end
          endcase
        end
      end else begin
        new_order_q <= '0;
      end
    end
  end

  assign order_1     = order_q[0];
  assign order_2     = order_q[1];
  assign order_3     = order_q[2];
  assign time_left_1 = time_q[0];
  assign time_left_2 = time_q[1];
  assign time_left_3 = time_q[2];
  assign order_valid = {state_q[2] == StActive, state_q[1] == StActive, state_q[0] == StActive};
  assign new_order   = new_order_q;
  assign score       = score_q;
  assign missed      = missed_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_order_generator.sv
// Scoreboard bench for order_generator: predicted fills are queued when a phase starts and
// popped whenever new_order pulses; fixed-cycle checks cover service, expiry and game_over.
module tb_order_generator;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned Timeout = 5;
  localparam int unsigned Refill  = 2;
  localparam int unsigned MaxMiss = 5;
  localparam logic [15:0] Seed    = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  done = 3'b000;
  logic [11:0] order_1, order_2, order_3;
  logic [2:0]  order_valid, new_order;
  logic [5:0]  time_left_1, time_left_2, time_left_3;
  logic [7:0]  score;
  logic [3:0]  missed;
  logic        game_over;

  always #5 clk = ~clk;

  order_generator #(
    .TICK_DIV      (TickDiv),
    .ORDER_TIMEOUT (Timeout),
    .REFILL_TICKS  (Refill),
    .MAX_MISSES    (MaxMiss),
    .LFSR_SEED     (Seed)
  ) u_dut (
    .basys_clk   (clk),
    .reset       (rst),
    .orders_done (done),
    .order_1     (order_1),
    .order_2     (order_2),
    .order_3     (order_3),
    .order_valid (order_valid),
    .new_order   (new_order),
    .time_left_1 (time_left_1),
    .time_left_2 (time_left_2),
    .time_left_3 (time_left_3),
    .score       (score),
    .missed      (missed),
    .game_over   (game_over)
  );

  typedef struct {
    int at_cyc;
    int slot;
  } fill_ev_t;

  fill_ev_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] l;
    logic        fb;
    l = Seed;
    for (int k = 0; k < n; k++) begin
      fb = l[15] ^ l[13] ^ l[12] ^ l[10];
      l  = {l[14:0], fb};
    end
    return l;
  endfunction

  function automatic logic [11:0] rom_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'h002;
      3'd1:    return 12'h010;
      3'd2:    return 12'h0C0;
      3'd3:    return 12'h600;
      3'd4:    return 12'h012;
      3'd5:    return 12'h6C0;
      3'd6:    return 12'h610;
      default: return 12'h6D2;
    endcase
  endfunction

  // The fill at edge N uses the LFSR value after N-1 shifts.
  function automatic logic [11:0] pred_word(input int at, input int slot);
    logic [15:0] l;
    l = lfsr_after(at - 1);
    return rom_word(l[3*slot +: 3]);
  endfunction

  function automatic logic in_rom(input logic [11:0] w);
    for (int k = 0; k < 8; k++) if (rom_word(3'(k)) == w) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [11:0] order_of(input int s);
    return (s == 0) ? order_1 : (s == 1) ? order_2 : order_3;
  endfunction

  function automatic logic [5:0] time_of(input int s);
    return (s == 0) ? time_left_1 : (s == 1) ? time_left_2 : time_left_3;
  endfunction

  task automatic push_fill(input int at, input int slot);
    fill_ev_t e;
    e.at_cyc = at;
    e.slot   = slot;
    exp_q.push_back(e);
  endtask

  task automatic step();
    fill_ev_t e;
    @(posedge clk);
    cyc++;
    #1;
    for (int s = 0; s < 3; s++) begin
      if (new_order[s]) begin
        check_eq("fill_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("fill_cycle", 32'(cyc), 32'(e.at_cyc));
          check_eq("fill_slot", 32'(s), 32'(e.slot));
`ifdef ORDER_GEN_NO_REPEAT_EN
          check_eq("fill_in_rom", 32'(in_rom(order_of(s))), 32'd1);
          for (int o = 0; o < 3; o++)
            if (o != s && order_valid[o]) check_eq("fill_distinct", 32'(order_of(o) == order_of(s)), 32'd0);
`else
          check_eq("fill_word", 32'(order_of(s)), 32'(pred_word(e.at_cyc, e.slot)));
`endif
          check_eq("fill_time", 32'(time_of(s)), 32'(Timeout));
          check_eq("fill_valid", 32'(order_valid[s]), 32'd1);
        end
      end
    end
  endtask

  task automatic do_reset();
    done = 3'b000;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    check_eq("rst_orders", {order_1, order_2, order_3}, 36'd0);
    check_eq("rst_valid_new", {order_valid, new_order}, 6'd0);
    check_eq("rst_times", {time_left_1, time_left_2, time_left_3}, 18'd0);
    check_eq("rst_counts", {score, missed, game_over}, 13'd0);
  endtask

  initial begin
    // Phase 1: no service, every order expires until game_over freezes the block.
    do_reset();
    push_fill(4, 0);  push_fill(8, 1);  push_fill(12, 2);
    push_fill(32, 0); push_fill(36, 1); push_fill(40, 2);
    repeat (160) begin
      step();
      if (cyc == 4)  check_eq("p1_valid_first", 32'(order_valid), 32'b001);
      if (cyc == 5)  check_eq("p1_pulse_once", 32'(new_order), 32'd0);
      if (cyc == 20) check_eq("p1_time_one", 32'(time_left_1), 32'd1);
      if (cyc == 24) begin
        check_eq("p1_expire_order", 32'(order_1), 32'd0);
        check_eq("p1_expire_valid", 32'(order_valid), 32'b110);
        check_eq("p1_missed_1", 32'(missed), 32'd1);
      end
      if (cyc == 56) check_eq("p1_missed5_no_go", {28'd0, missed, game_over}, 32'h0000_000A);
      if (cyc == 57) check_eq("p1_game_over", 32'(game_over), 32'd1);
    end
    check_eq("frz_game_over", 32'(game_over), 32'd1);
    check_eq("frz_counts", {score, missed}, 12'h005);
    check_eq("frz_valid", 32'(order_valid), 32'b100);
    check_eq("frz_orders12", {order_1, order_2}, 24'd0);
    check_eq("frz_times", {time_left_1, time_left_2, time_left_3}, 18'd1);
    check_eq("frz_new", 32'(new_order), 32'd0);
`ifdef ORDER_GEN_NO_REPEAT_EN
    check_eq("frz_order3", 32'(in_rom(order_3)), 32'd1);
`else
    check_eq("frz_order3", 32'(order_3), 32'(pred_word(40, 2)));
`endif
    check_eq("p1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Phase 2: held done counts once; done on the expiry tick wins over the miss.
    do_reset();
    push_fill(4, 0); push_fill(8, 1); push_fill(12, 0); push_fill(12, 2);
    repeat (30) begin
      step();
      if (cyc == 6) begin
        check_eq("p2_score_1", 32'(score), 32'd1);
        check_eq("p2_cleared", {20'd0, order_1}, 32'd0);
        check_eq("p2_valid_low", 32'(order_valid), 32'b000);
      end
      if (cyc == 12) check_eq("p2_refill_valid", 32'(order_valid), 32'b111);
      if (cyc == 15) check_eq("p2_score_hold", 32'(score), 32'd1);
      if (cyc == 27) check_eq("p2_time2_one", 32'(time_left_2), 32'd1);
      if (cyc == 28) begin
        check_eq("p2_done_wins_score", 32'(score), 32'd2);
        check_eq("p2_done_wins_miss", 32'(missed), 32'd0);
        check_eq("p2_done_valid", 32'(order_valid), 32'b101);
      end
      if (cyc == 5)  done = 3'b001;
      if (cyc == 15) done = 3'b000;
      if (cyc == 27) done = 3'b010;
      if (cyc == 29) done = 3'b000;
    end
    check_eq("p2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Phase 3: mid-game reset restarts the same staggered, seeded sequence.
    do_reset();
    push_fill(4, 0); push_fill(8, 1); push_fill(12, 2);
    repeat (14) step();
    check_eq("p3_queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("p3_valid", 32'(order_valid), 32'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
